bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq_pkg.sv | 26 ++
 rtl/bin_to_bcd_seq_if.sv | 31 +++
 rtl/bin_to_bcd_seq_add3.sv | 21 ++
 rtl/bin_to_bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit geometry and the add-3 correction threshold.
package bin_to_bcd_seq_pkg;

    // FSM state encoding (plain constants so legacy tools can consume them)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One packed BCD digit is a nibble
    localparam int BCD_DIGIT_W = 4;

    // Digits at or above this value get +3 before the next shift
    localparam int ADD3_THRESHOLD = 5;

    // 10^n, used to check at elaboration that DIGITS can hold the largest input
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and the BCD converter.
// The master issues start/bin, the slave (converter) returns busy/done/bcd/blank.
interface bin_to_bcd_seq_if #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
);
    logic                start;
    logic [IN_W-1:0]     bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  blank
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output blank
    );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit double-dabble corrector: digits of 5..15 get +3 so that the
// following left shift carries correctly into the next decade.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(ADD3_THRESHOLD);

    // Purely combinational correction of one digit
    always_comb begin
        if (i_digit >= THRESH) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter feeding the 7-segment decoders.
// One bit is shifted per cycle; BCD and the leading-zero blank mask are only
// updated on the edge that raises done, so the display never sees partial data.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic           i_clock,
    input  logic           i_resetn,
    bin_to_bcd_seq_if.slave bus
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CAT_W = SCR_W + IN_W;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(IN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RESET = ~(DIGITS'(1));

    // The digit count must be able to represent 2^IN_W - 1
    if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_bad_params
        $error("bin_to_bcd_seq: DIGITS too small for IN_W");
    end

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IN_W-1:0]   r_shift;
    logic [SCR_W-1:0]  r_scratch;
    logic [SCR_W-1:0]  r_bcd;
    logic [DIGITS-1:0] r_blank;
    logic              r_busy;
    logic              r_done;

    logic [SCR_W-1:0]  w_corr;
    logic [CAT_W-1:0]  w_cat_sh;
    logic [SCR_W-1:0]  w_scr_next;
    logic [IN_W-1:0]   w_shift_next;
    logic [DIGITS-1:0] w_blank;

    // One corrector per digit, applied before this cycle's shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_cat_sh     = {w_corr, r_shift} << 1;
    assign w_scr_next   = w_cat_sh[CAT_W-1:IN_W];
    assign w_shift_next = w_cat_sh[IN_W-1:0];

    // Leading-zero mask: blank from the top digit down until a nonzero digit;
    // the units digit is never blanked so zero still shows as "0"
    always_comb begin
        logic v_seen_nz;
        v_seen_nz = 1'b0;
        w_blank   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_scr_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0) begin
                v_seen_nz = 1'b1;
            end else begin
                v_seen_nz = v_seen_nz;
            end
            w_blank[i] = ~v_seen_nz;
        end
        w_blank[0] = 1'b0;
    end

    // Conversion FSM, shift datapath and registered result outputs
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_blank   <= BLANK_RESET;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shift   <= bus.bin;
                        r_scratch <= '0;
                        r_cnt     <= CNT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_scr_next;
                    r_shift   <= w_shift_next;
                    if (r_cnt == '0) begin
                        r_bcd   <= w_scr_next;
                        r_blank <= w_blank;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.bcd   = r_bcd;
    assign bus.blank = r_blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a cycle-level behavioural model
// (decimal arithmetic, conversion age counter) checked every cycle, plus
// directed scenarios with hand-computed results.
module tb_bin_to_bcd_seq;

    localparam int IN_W   = 10;
    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .i_clock  (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] exp_bcd(input int v);
        logic [15:0] r;
        int p;
        r = 16'h0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_blank(input int v);
        logic [3:0] b;
        int p;
        b = 4'b0000;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    logic        m_busy;
    logic        m_done;
    int          m_age;
    int          m_val;
    logic [15:0] m_bcd;
    logic [3:0]  m_blank;
    bit          model_ok;

    // Model: accept start when idle, result appears IN_W+1 cycles later, idle one cycle after
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_age   <= 0;
            m_val   <= 0;
            m_bcd   <= 16'h0000;
            m_blank <= 4'b1110;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_busy <= 1'b1;
                m_val  <= int'(bus.bin);
                m_age  <= 1;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age == IN_W) begin
                m_done  <= 1'b1;
                m_bcd   <= exp_bcd(m_val);
                m_blank <= exp_blank(m_val);
            end else begin
                m_done <= 1'b0;
            end
            if (m_age == IN_W + 1) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle out of reset, DUT outputs must equal the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && model_ok) begin
                chk("busy",  32'(bus.busy),  32'(m_busy));
                chk("done",  32'(bus.done),  32'(m_done));
                chk("bcd",   32'(bus.bcd),   32'(m_bcd));
                chk("blank", 32'(bus.blank), 32'(m_blank));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic convert(input int v, input logic [15:0] eb, input logic [3:0] ebl);
        int n;
        bit got;
        bus.bin   = 10'(v);
        bus.start = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        chk("conv_done_seen", 32'(got), 32'd1);
        chk("conv_latency", 32'(n), 32'd11);
        chk("conv_bcd", 32'(bus.bcd), 32'(eb));
        chk("conv_blank", 32'(bus.blank), 32'(ebl));
        @(negedge clk);
        chk("conv_idle_after", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  ndone;
        bit  got;
        checks    = 0;
        failures  = 0;
        model_ok  = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = 10'd0;

        // pin the model against hand-computed values
        chk("model_bcd_1023",  32'(exp_bcd(1023)), 32'h1023);
        chk("model_bcd_45",    32'(exp_bcd(45)),   32'h0045);
        chk("model_blank_0",   32'(exp_blank(0)),   32'hE);
        chk("model_blank_999", 32'(exp_blank(999)), 32'h8);
        chk("model_blank_100", 32'(exp_blank(100)), 32'h8);

        // reset 3 cycles then idle 20 cycles
        repeat (3) @(negedge clk);
        chk("rst_bcd",   32'(bus.bcd),   32'h0);
        chk("rst_blank", 32'(bus.blank), 32'hE);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        chk("rst_done",  32'(bus.done),  32'h0);
        #2 rst_n = 1'b1;
        model_ok = 1'b1;
        repeat (20) @(negedge clk);

        // maximum value, then small and three-digit values
        convert(1023, 16'h1023, 4'b0000);
        convert(7,    16'h0007, 4'b1110);
        convert(999,  16'h0999, 4'b1000);
        convert(0,    16'h0000, 4'b1110);

        // start held high: back-to-back conversions, bin changed mid-flight
        bus.bin   = 10'd512;
        bus.start = 1'b1;
        wait_done(n, got);
        chk("held_first_lat", 32'(n), 32'd11);
        chk("held_first_bcd", 32'(bus.bcd), 32'h0512);
        wait_done(n, got);
        chk("held_period", 32'(n), 32'd12);
        chk("held_second_bcd", 32'(bus.bcd), 32'h0512);
        @(negedge clk);
        @(negedge clk);
        bus.bin = 10'd100;
        wait_done(n, got);
        chk("held_bin_change_period", 32'(n + 2), 32'd12);
        chk("held_inflight_bcd", 32'(bus.bcd), 32'h0512);
        wait_done(n, got);
        chk("held_next_period", 32'(n), 32'd12);
        chk("held_next_bcd", 32'(bus.bcd), 32'h0100);
        chk("held_next_blank", 32'(bus.blank), 32'h8);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);

        // start re-pulsed during a conversion is ignored
        bus.bin   = 10'd45;
        bus.start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 4) begin
                bus.start = 1'b1;
                bus.bin   = 10'd999;
            end
            if (k == 5) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                chk("repulse_lat", 32'(k), 32'd11);
                chk("repulse_bcd", 32'(bus.bcd), 32'h0045);
            end
        end
        chk("repulse_done_count", 32'(ndone), 32'd1);

        // reset in the middle of a conversion
        convert(300, 16'h0300, 4'b1000);
        bus.bin   = 10'd88;
        bus.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bcd",   32'(bus.bcd),   32'h0);
        chk("midrst_busy",  32'(bus.busy),  32'h0);
        chk("midrst_blank", 32'(bus.blank), 32'hE);
        chk("midrst_done",  32'(bus.done),  32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        convert(88, 16'h0088, 4'b1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
